// File: rtl/lift_group_dispatcher.sv
// lift_group_dispatcher: latches hall calls, assigns each to one car by distance/direction cost scan, clears on service.
// Optional DISPATCH_TIMEOUT_EN: stale assignments age out after TIMEOUT_CYCLES and are reassigned to another car.
module lift_group_dispatcher #(
  parameter int NUM_CARS = 3,
  parameter int NUM_FLOORS = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CARS-1:0]            emergency,
  input  logic [NUM_CARS*FW-1:0]         car_floor,
  input  logic [NUM_CARS-1:0]            car_move_up,
  input  logic [NUM_CARS-1:0]            car_move_down,
  input  logic [NUM_CARS-1:0]            car_door_open,
  input  logic [NUM_FLOORS-1:0]          hall_up_req,
  input  logic [NUM_FLOORS-1:0]          hall_down_req,
  output logic [NUM_CARS*NUM_FLOORS-1:0] assigned_up,
  output logic [NUM_CARS*NUM_FLOORS-1:0] assigned_down,
  output logic [NUM_FLOORS-1:0]          led_hall_up,
  output logic [NUM_FLOORS-1:0]          led_hall_down,
  output logic                           assign_valid,
  output logic [2:0]                     assign_car,
  output logic [FW-1:0]                  assign_floor,
  output logic                           assign_dir_up
);
  localparam int S = 2 * NUM_FLOORS;
  localparam int PW = $clog2(S);
  localparam int CW = PW + 1;
  localparam int OW = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1;
  logic [S-1:0] pend, asg, pend_n, asg_n, req, slot_ok, svc, tmo;
  logic [OW-1:0] own [S];
  logic [OW-1:0] own_n [S];
  logic [FW-1:0] slot_fl [S];
  logic [FW-1:0] cfl [NUM_CARS];
  logic [CW-1:0] cost [NUM_CARS];
  logic [PW-1:0] ptr;
  logic [FW-1:0] ev_fl;
  logic ev_up, ev_go, found;
  logic [NUM_CARS-1:0] elig;
  logic [OW-1:0] best;
  logic [CW-1:0] best_cost;
  logic [NUM_CARS*NUM_FLOORS-1:0] au_n, ad_n;

  for (genvar s = 0; s < S; s++) begin : g_slot
    assign slot_fl[s] = FW'(s % NUM_FLOORS);
    assign slot_ok[s] = s < NUM_FLOORS ? (s != NUM_FLOORS - 1) : (s != NUM_FLOORS);
    assign svc[s] = asg[s] && car_door_open[own[s]] && cfl[own[s]] == slot_fl[s];
  end
  assign req = {hall_down_req, hall_up_req} & slot_ok;
  assign ev_fl = slot_fl[ptr];
  assign ev_up = ptr < PW'(NUM_FLOORS);

  for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
    logic [FW-1:0] d;
    logic toward;
    assign cfl[c] = car_floor[c*FW +: FW];
    assign d = cfl[c] > ev_fl ? cfl[c] - ev_fl : ev_fl - cfl[c];
    assign toward = (!car_move_up[c] && !car_move_down[c]) ||
                    (ev_up ? car_move_up[c] && cfl[c] <= ev_fl : car_move_down[c] && cfl[c] >= ev_fl);
    assign cost[c] = toward ? CW'(d) : CW'(d) + CW'(NUM_FLOORS);
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  logic [AW-1:0] age [S];
  logic [OW-1:0] prev [S];
  logic [S-1:0] excl;
  logic [NUM_CARS-1:0] prev_oh;
  for (genvar s = 0; s < S; s++) begin : g_tmo
    assign tmo[s] = asg[s] && age[s] == AW'(TIMEOUT_CYCLES);
  end
  assign prev_oh = NUM_CARS'(1) << prev[ptr];
  // A timed-out owner is skipped only if some other car can take the call.
  assign elig = ~emergency & ((excl[ptr] && |(~emergency & ~prev_oh)) ? ~prev_oh : '1);
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '{default: '0};
      prev <= '{default: '0};
      excl <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        age[s] <= (!asg[s] || tmo[s] || svc[s]) ? '0 : age[s] + 1'b1;
        if (tmo[s]) begin
          excl[s] <= 1'b1;
          prev[s] <= own[s];
        end else if (svc[s] || (ev_go && PW'(s) == ptr)) excl[s] <= 1'b0;
      end
    end
  end
`else
  assign tmo = '0;
  assign elig = ~emergency;
`endif

  always_comb begin
    found = 1'b0;
    best = '0;
    best_cost = '0;
    for (int c = 0; c < NUM_CARS; c++)
      if (elig[c] && (!found || cost[c] < best_cost)) begin
        found = 1'b1;
        best = OW'(c);
        best_cost = cost[c];
      end
  end
  assign ev_go = pend[ptr] && !asg[ptr] && found;

  // Service clear is applied last so it overrides a same-cycle re-press.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      pend_n[s] = pend[s] | req[s];
      asg_n[s] = asg[s] && !emergency[own[s]] && !tmo[s];
      own_n[s] = own[s];
      if (ev_go && PW'(s) == ptr) begin
        asg_n[s] = 1'b1;
        own_n[s] = best;
      end
      if (svc[s]) begin
        pend_n[s] = 1'b0;
        asg_n[s] = 1'b0;
      end
    end
  end

  always_comb begin
    au_n = '0;
    ad_n = '0;
    for (int c = 0; c < NUM_CARS; c++)
      for (int f = 0; f < NUM_FLOORS; f++) begin
        au_n[c*NUM_FLOORS+f] = asg_n[f] && own_n[f] == OW'(c);
        ad_n[c*NUM_FLOORS+f] = asg_n[NUM_FLOORS+f] && own_n[NUM_FLOORS+f] == OW'(c);
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      asg <= '0;
      own <= '{default: '0};
      ptr <= '0;
      assigned_up <= '0;
      assigned_down <= '0;
      led_hall_up <= '0;
      led_hall_down <= '0;
      assign_valid <= 1'b0;
      assign_car <= '0;
      assign_floor <= '0;
      assign_dir_up <= 1'b0;
    end else begin
      pend <= pend_n;
      asg <= asg_n;
      own <= own_n;
      ptr <= ptr == PW'(S - 1) ? '0 : ptr + 1'b1;
      assigned_up <= au_n;
      assigned_down <= ad_n;
      led_hall_up <= pend_n[NUM_FLOORS-1:0];
      led_hall_down <= pend_n[S-1:NUM_FLOORS];
      assign_valid <= ev_go;
      assign_car <= ev_go ? 3'(best) : '0;
      assign_floor <= ev_go ? ev_fl : '0;
      assign_dir_up <= ev_go && ev_up;
    end
  end
endmodule

// File: tb/tb_lift_group_dispatcher.sv
// tb_lift_group_dispatcher: directed scenarios; expected assignments queued at stimulus, matched by a monitor on assign_valid.
module tb_lift_group_dispatcher;
  localparam int NC = 3;
  localparam int NF = 6;
  localparam int FW = 3;
  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0] emergency, car_move_up, car_move_down, car_door_open;
  logic [NC*FW-1:0] car_floor;
  logic [NF-1:0] hall_up_req, hall_down_req, led_hall_up, led_hall_down;
  logic [NC*NF-1:0] assigned_up, assigned_down;
  logic assign_valid, assign_dir_up;
  logic [2:0] assign_car;
  logic [FW-1:0] assign_floor;
  int tests = 0;
  int fails = 0;
  logic [6:0] q[$];

  lift_group_dispatcher #(.NUM_CARS(NC), .NUM_FLOORS(NF), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .emergency(emergency), .car_floor(car_floor),
    .car_move_up(car_move_up), .car_move_down(car_move_down), .car_door_open(car_door_open),
    .hall_up_req(hall_up_req), .hall_down_req(hall_down_req),
    .assigned_up(assigned_up), .assigned_down(assigned_down),
    .led_hall_up(led_hall_up), .led_hall_down(led_hall_down),
    .assign_valid(assign_valid), .assign_car(assign_car),
    .assign_floor(assign_floor), .assign_dir_up(assign_dir_up)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    int k;
    forever begin
      @(negedge clk);
      if (assign_valid) begin
        k = -1;
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i] == {assign_car, assign_floor, assign_dir_up}) k = i;
        tests++;
        if (k < 0) begin
          fails++;
          $display("FAIL assign: got car %0d floor %0d dir_up %0b, required one of %0d outstanding expected",
                   assign_car, assign_floor, assign_dir_up, q.size());
        end else q.delete(k);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_car(input int c, input int f, input logic up, input logic dn);
    car_floor[c*FW +: FW] = FW'(f);
    car_move_up[c] = up;
    car_move_down[c] = dn;
  endtask

  task automatic expect_asg(input int c, input int f, input logic up);
    q.push_back({3'(c), 3'(f), up});
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d assignments outstanding after %0d cycles, required 0", name, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic pulse(input logic up, input int f);
    if (up) hall_up_req[f] = 1'b1;
    else hall_down_req[f] = 1'b1;
    tick(1);
    hall_up_req = '0;
    hall_down_req = '0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    emergency = '0;
    car_move_up = '0;
    car_move_down = '0;
    car_door_open = '0;
    car_floor = '0;
    hall_up_req = '0;
    hall_down_req = '0;
    tick(3);
    rst = 1'b0;
    q.delete();
    chk({name, "_rst_out"}, {14'(0), assign_valid, assign_car, assign_floor, assign_dir_up, led_hall_up, led_hall_down}, 0);
    chk({name, "_rst_asg"}, {assigned_up, assigned_down}, 0);
    set_car(0, 0, 0, 0);
    set_car(1, 3, 0, 0);
    set_car(2, 5, 0, 0);
  endtask

  initial begin
    do_reset("s1");
    expect_asg(1, 2, 1);
    pulse(1, 2);
    drain(2 * NF + 2, "s1_drain");
    chk("s1_asg_up", assigned_up, 32'h1 << (1 * NF + 2));
    chk("s1_led_up", led_hall_up, 32'h1 << 2);
`ifndef DISPATCH_TIMEOUT_EN
    tick(40);
    chk("s1_persist", assigned_up, 32'h1 << (1 * NF + 2));
`endif

    do_reset("s2");
    set_car(1, 4, 0, 0);
    expect_asg(0, 2, 1);
    pulse(1, 2);
    drain(2 * NF + 2, "s2_tie");

    do_reset("s3");
    set_car(1, 1, 1, 0);
    set_car(2, 5, 0, 1);
    expect_asg(2, 3, 0);
    pulse(0, 3);
    drain(2 * NF + 2, "s3_drain");
    chk("s3_asg_dn", assigned_down, 32'h1 << (2 * NF + 3));
    chk("s3_led_dn", led_hall_down, 32'h1 << 3);
    set_car(2, 3, 0, 0);
    car_door_open[2] = 1'b1;
    tick(1);
    car_door_open = '0;
    chk("s3_clr_led", led_hall_down, 0);
    chk("s3_clr_asg", assigned_down, 0);

    do_reset("s4");
    expect_asg(1, 2, 1);
    pulse(1, 2);
    drain(2 * NF + 2, "s4_first");
    expect_asg(0, 2, 1);
    emergency[1] = 1'b1;
    tick(1);
    chk("s4_emerg_drop", assigned_up[1*NF +: NF], 0);
    chk("s4_emerg_led", led_hall_up, 32'h1 << 2);
    drain(2 * NF, "s4_reassign");
    chk("s4_car0", assigned_up, 32'h1 << 2);
    emergency = '1;
    pulse(0, 4);
    tick(30);
    chk("s4_all_led", {led_hall_up, led_hall_down}, {6'b000100, 6'b010000});
    chk("s4_all_asg", {assigned_up, assigned_down}, 0);
    expect_asg(2, 2, 1);
    expect_asg(2, 4, 0);
    emergency[2] = 1'b0;
    drain(2 * NF + 2, "s4_release");
    chk("s4_rel_asg", {assigned_up, assigned_down}, {18'h1 << (2 * NF + 2), 18'h1 << (2 * NF + 4)});

    do_reset("s5");
    expect_asg(1, 4, 1);
    pulse(1, 4);
    drain(2 * NF + 2, "s5_drain");
    set_car(1, 4, 0, 0);
    car_door_open[1] = 1'b1;
    hall_up_req[4] = 1'b1;
    tick(1);
    car_door_open = '0;
    hall_up_req = '0;
    chk("s5_clr_led", led_hall_up, 0);
    tick(2 * NF + 3);
    chk("s5_no_relatch", {led_hall_up, assigned_up}, 0);

    do_reset("s6");
    hall_up_req[NF-1] = 1'b1;
    hall_down_req[0] = 1'b1;
    tick(1);
    hall_up_req = '0;
    hall_down_req = '0;
    chk("s6_ignored_led", {led_hall_up, led_hall_down}, 0);
    tick(2 * NF + 3);
    chk("s6_ignored_asg", {assigned_up, assigned_down}, 0);

`ifdef DISPATCH_TIMEOUT_EN
    do_reset("s7");
    expect_asg(1, 2, 1);
    pulse(1, 2);
    drain(2 * NF + 2, "s7_first");
    expect_asg(0, 2, 1);
    drain(20 + 2 * NF + 2, "s7_timeout");
    chk("s7_moved", assigned_up, 32'h1 << 2);
    do_reset("s7_end");
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lift_group_dispatcher.md
# lift_group_dispatcher

Parametrised group dispatcher for a bank of NUM_CARS lifts serving NUM_FLOORS floors; the next generation of the fixed three-car, six-floor hall-call master. It latches hall up/down requests, assigns each pending call to exactly one car by a distance/direction cost scan, and clears calls when the assigned car opens its door at that floor. Emergency cars are excluded, and their calls are redistributed. It sits between the hall push-buttons and the per-car call registers and controllers.

## Interface
- NUM_CARS, 3, number of cars (1..8)
- NUM_FLOORS, 6, number of floors (2..16); FW = $clog2(NUM_FLOORS) is a local width
- TIMEOUT_CYCLES, 1024, age at which an unserved assigned call is reassigned (used only with DISPATCH_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- emergency  in  NUM_CARS  level; 1 = car out of service
- car_floor  in  NUM_CARS*FW  current floor per car, car c at [c*FW +: FW]
- car_move_up, car_move_down  in  NUM_CARS  car motion status; both 0 = idle
- car_door_open  in  NUM_CARS  door open at car_floor
- hall_up_req  in  NUM_FLOORS  request pulses; bit NUM_FLOORS-1 ignored
- hall_down_req  in  NUM_FLOORS  request pulses; bit 0 ignored
- assigned_up, assigned_down  out  NUM_CARS*NUM_FLOORS  per-car assigned calls, car c at [c*NUM_FLOORS +: NUM_FLOORS]
- led_hall_up, led_hall_down  out  NUM_FLOORS  pending (assigned or not) calls
- assign_valid  out  1  one-cycle strobe: an assignment was made
- assign_car  out  3  car index of that assignment
- assign_floor  out  FW  floor of that assignment
- assign_dir_up  out  1  1 = up call, 0 = down call

## Operation
- Slots: 2*NUM_FLOORS call slots. Slot s < NUM_FLOORS is up call floor s. Slot s >= NUM_FLOORS is down call floor s-NUM_FLOORS. Invalid slots (up at top floor, down at floor 0) never become pending.
- Per slot: a pending bit, an assigned bit, and an owner car index.
- Latch: a request bit high sets pending. Repeat requests while pending have no effect.
- Scan: the pointer advances one slot per cycle, 0..2*NUM_FLOORS-1, then wraps to 0. It advances every cycle, including cycles with no pending calls.
- Eligibility and cost, evaluated for the slot under the pointer when that slot is pending and unassigned:
  - A car is eligible when emergency[c] = 0.
  - dist = |car_floor - call floor|.
  - cost = dist if the car is idle, or if it is moving toward the call floor in the call's direction (dist 0 counts as toward).
  - Otherwise cost = dist + NUM_FLOORS.
  - The minimum cost wins; ties go to the lowest car index.
  - With no eligible car, the slot stays pending and unassigned.
- Service clear: when car_door_open[c] is 1 and car_floor[c] equals the floor of a slot owned by c, pending and assigned are cleared for that slot. This applies to both directions at that floor when both are owned by c.
- Clear vs set in the same cycle: clear wins; a new request must be re-pressed.
- Emergency: while emergency[c] = 1, every slot owned by c drops to unassigned (still pending) and is re-scanned. assigned_* for car c reads 0 from the next cycle.
- LED and assigned outputs are registered decodes of the slot state.

## Timing
- Reset: all outputs 0; all slot state cleared; pointer = 0; any pending calls are discarded.
- Request at edge N: led_hall_* is high after edge N+1.
- Assignment: the pointer reaches the slot within at most 2*NUM_FLOORS cycles after the latch. assigned_* and assign_valid assert one cycle after that evaluation.
- assign_valid is high for exactly one cycle per assignment, with at most one assignment per cycle.
- Service clear: the cycle after door-open with a floor match, the LED and assigned bits are 0.
- Emergency release: the car becomes eligible in the next evaluation; existing assignments are not moved back.
- Car inputs are sampled in the evaluation cycle only; no hazard checking is done on them.

## Configuration
- DISPATCH_TIMEOUT_EN defined:
  - Each assigned slot has an age counter that increments every cycle.
  - At age == TIMEOUT_CYCLES the slot reverts to unassigned and the age resets.
  - The next evaluation excludes the previous owner unless it is the only eligible car.
  - The age counter clears on service or reassignment.
- DISPATCH_TIMEOUT_EN undefined: no counters; an assignment persists until service or emergency.

## Test plan
- Defaults: rst 3 cycles, then idle cars at floors 0/3/5; pulse hall_up_req[2] -> within 13 cycles assign_valid with car 1, floor 2, up; assigned_up[1*6+2] = 1; led_hall_up[2] = 1.
- Car 0 idle at 0 and car 1 idle at 4 (equal distance); call up at floor 2 -> car 0 wins the tie.
- Car 2 at floor 5 moving down, car 0 idle at 0; down call at floor 3 -> car 2 (cost 2) wins; car 2 door open at 3 -> led_hall_down[3] = 0 next cycle.
- Call assigned to car 1, then emergency[1] = 1 -> assigned_up for car 1 = 0 next cycle, reassigned to another car within 12 cycles; with all emergency bits = 1, led stays 1 and no assign_valid.
- Door-open at floor 4 coincident with a new hall_up_req[4] pulse for the owner -> the call clears and is not re-latched.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES = 20, the owner never opens its door -> reassigned to a different car within 20+12 cycles.
